clm_rand_supplier: RTL and testbench

Double-buffered randomness source for the serial CLM multiplier. It generates the `2*(8+d)` reduction-polynomial-width refresh words the multiplier latches on `drdy_i`, keeps a fresh vector ready at all times, and flags any multiplication started without fresh randomness. It sits directly upstream of the multiplier's `random_vect` input, beside the controller that pulses `drdy_i`.

---
 rtl/clm_rand_supplier.sv | 122 ++++++++++++
 tb/tb_clm_rand_supplier.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_rand_supplier.sv
// Double-buffered LFSR randomness supplier for the serial CLM multiplier.
// Optional macro CLM_RNG_SCRUB_EN clears the front vector whenever rdy_o falls.
module clm_rand_supplier #(
    parameter int          d    = 4,
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            seed_i,
    input  logic                   seed_load_i,
    input  logic                   take_i,
    output logic [2*(8+d)*d-1:0]   random_vect_o,
    output logic                   rdy_o,
    output logic                   underflow_o
);

    localparam int W  = 2 * (8 + d);
    localparam int IW = $clog2(W);

`ifdef CLM_RNG_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_adv;
    logic [IW-1:0]   fill_idx;
    logic [W*d-1:0]  back;
    logic            do_write;
    logic            do_swap;

    // Fibonacci x^32+x^22+x^2+x+1, unrolled d steps so one full word emerges per cycle.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < d; i++) begin
            r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
        end
        return r;
    endfunction

    assign lfsr_adv = lfsr_advance(lfsr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        do_swap    = 1'b0;
        if (seed_load_i) begin
            next_state = FILL;
        end else begin
            case (state)
                FILL: begin
                    do_write = 1'b1;
                    if (fill_idx == IW'(W - 1)) begin
                        next_state = FULL;
                    end
                end
                FULL: begin
                    // Swap when the front is empty or is being consumed right now.
                    if (!rdy_o || take_i) begin
                        do_swap    = 1'b1;
                        next_state = FILL;
                    end
                end
                default: next_state = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr          <= SEED;
            fill_idx      <= '0;
            back          <= '0;
            random_vect_o <= '0;
            rdy_o         <= 1'b0;
            underflow_o   <= 1'b0;
        end else if (seed_load_i) begin
            lfsr     <= (seed_i == 32'd0) ? SEED : seed_i;
            fill_idx <= '0;
            rdy_o    <= 1'b0;
            if (SCRUB) begin
                random_vect_o <= '0;
            end
        end else begin
            if (take_i && !rdy_o) begin
                underflow_o <= 1'b1;
            end
            if (do_write) begin
                back[fill_idx*d +: d] <= lfsr_adv[d-1:0];
                lfsr                  <= lfsr_adv;
                fill_idx              <= (fill_idx == IW'(W - 1)) ? '0 : fill_idx + IW'(1);
            end
            if (do_swap) begin
                random_vect_o <= back;
                rdy_o         <= 1'b1;
            end else if (take_i && rdy_o) begin
                rdy_o <= 1'b0;
                if (SCRUB) begin
                    random_vect_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clm_rand_supplier.sv
// Randomised and directed bench for clm_rand_supplier against a queue-based reference model.
// Honours CLM_RNG_SCRUB_EN the same way the design does.
module tb_clm_rand_supplier;

    localparam int          D    = 4;
    localparam logic [31:0] SEED = 32'h1;
    localparam int          W    = 2 * (8 + D);

    logic              clk;
    logic              rst;
    logic [31:0]       seed_i;
    logic              seed_load_i;
    logic              take_i;
    logic [W*D-1:0]    random_vect_o;
    logic              rdy_o;
    logic              underflow_o;

    int checks;
    int errors;

    clm_rand_supplier #(.d(D), .SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .seed_i       (seed_i),
        .seed_load_i  (seed_load_i),
        .take_i       (take_i),
        .random_vect_o(random_vect_o),
        .rdy_o        (rdy_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: LFSR value, queue of pending words, front vector and flags.
    logic [31:0]    m_lfsr;
    logic [D-1:0]   m_back[$];
    bit             m_full;
    logic [W*D-1:0] m_front;
    bit             m_rdy;
    bit             m_uf;
    logic [W*D-1:0] vec1_ref;

    function automatic logic [31:0] golden_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic bit scrub_on();
`ifdef CLM_RNG_SCRUB_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit r, input bit sl, input logic [31:0] seed, input bit take);
        if (!r) begin
            m_lfsr = SEED;
            m_back.delete();
            m_full  = 0;
            m_front = '0;
            m_rdy   = 0;
            m_uf    = 0;
        end else if (sl) begin
            m_lfsr = (seed == 0) ? SEED : seed;
            m_back.delete();
            m_full = 0;
            if (m_rdy && scrub_on()) m_front = '0;
            m_rdy = 0;
        end else begin
            if (take && !m_rdy) m_uf = 1;
            if (m_full) begin
                if (!m_rdy || take) begin
                    for (int k = 0; k < W; k++) m_front[k*D +: D] = m_back[k];
                    m_back.delete();
                    m_full = 0;
                    m_rdy  = 1;
                end
            end else begin
                for (int i = 0; i < D; i++) m_lfsr = golden_step(m_lfsr);
                m_back.push_back(m_lfsr[D-1:0]);
                if (m_back.size() == W) m_full = 1;
                if (take && m_rdy) begin
                    m_rdy = 0;
                    if (scrub_on()) m_front = '0;
                end
            end
        end
    endtask

    task automatic tick(input bit sl, input logic [31:0] seed, input bit take);
        seed_load_i = sl;
        seed_i      = seed;
        take_i      = take;
        @(posedge clk);
        model_step(rst, sl, seed, take);
        #1;
        seed_load_i = 1'b0;
        take_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy got %b want 0", rdy_o); end
        checks++;
        if (underflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_uf got %b want 0", underflow_o); end
        checks++;
        if (random_vect_o !== '0) begin errors++; $display("[TB] FAIL reset_vect got %h want 0", random_vect_o); end
    endtask

    task automatic test_startup();
        rst = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick(0, 0, 0);
            if (e == 24) begin
                checks++;
                if (rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL startup_rdy_e24 got %b want 0", rdy_o); end
            end
        end
        vec1_ref = m_front;
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL startup_rdy_e25 got %b want 1", rdy_o); end
        checks++;
        if (random_vect_o !== m_front) begin errors++; $display("[TB] FAIL startup_vect got %h want %h", random_vect_o, m_front); end
        checks++;
        if (random_vect_o[3:0] !== 4'hB) begin errors++; $display("[TB] FAIL startup_word0 got %h want b", random_vect_o[3:0]); end
        for (int e = 26; e <= 49; e++) tick(0, 0, 0);
        checks++;
        if (rdy_o !== 1'b1 || random_vect_o !== vec1_ref) begin
            errors++; $display("[TB] FAIL hold_e49 got rdy=%b vect=%h want rdy=1 vect=%h", rdy_o, random_vect_o, vec1_ref);
        end
    endtask

    task automatic test_take_full();
        int n;
        int expect_n;
        tick(0, 0, 1);
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL take_full_rdy got %b want 1", rdy_o); end
        checks++;
        if (random_vect_o !== m_front) begin errors++; $display("[TB] FAIL take_full_vect got %h want %h", random_vect_o, m_front); end
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL take_full_hold got %b want 1", rdy_o); end
        expect_n = W - m_back.size();
        tick(0, 0, 1);
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL take_fill_rdy got %b want 0", rdy_o); end
        n = 0;
        do begin
            tick(0, 0, 0);
            n++;
        end while (rdy_o !== 1'b1 && n < 60);
        checks++;
        if (n != expect_n) begin errors++; $display("[TB] FAIL take_to_ready got %0d want %0d", n, expect_n); end
        checks++;
        if (random_vect_o !== m_front) begin errors++; $display("[TB] FAIL refill_vect got %h want %h", random_vect_o, m_front); end
    endtask

    task automatic test_underflow();
        int zeros;
        rst = 1'b0;
        tick(0, 0, 0);
        rst = 1'b1;
        for (int e = 1; e <= 25; e++) tick(0, 0, 0);
        tick(0, 0, 1);
        zeros = (rdy_o === 1'b0) ? 1 : 0;
        for (int i = 0; i < 60 && rdy_o !== 1'b1; i++) begin
            tick(0, 0, (i == 4));
            if (rdy_o === 1'b0) zeros++;
            if (i == 4) begin
                checks++;
                if (underflow_o !== 1'b1) begin errors++; $display("[TB] FAIL underflow_set got %b want 1", underflow_o); end
            end
        end
        checks++;
        if (zeros != 24) begin errors++; $display("[TB] FAIL gap_len got %0d want 24", zeros); end
        for (int i = 0; i < 30; i++) tick(0, 0, 0);
        checks++;
        if (underflow_o !== 1'b1) begin errors++; $display("[TB] FAIL underflow_sticky got %b want 1", underflow_o); end
    endtask

    task automatic test_reseed();
        int n;
        rst = 1'b0;
        tick(0, 0, 0);
        rst = 1'b1;
        checks++;
        if (underflow_o !== 1'b0) begin errors++; $display("[TB] FAIL uf_cleared got %b want 0", underflow_o); end
        for (int e = 1; e <= 10; e++) tick(0, 0, 0);
        tick(1, 32'd0, 0);
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL reseed_rdy got %b want 0", rdy_o); end
        n = 0;
        do begin
            tick(0, 0, 0);
            n++;
        end while (rdy_o !== 1'b1 && n < 60);
        checks++;
        if (n != 25) begin errors++; $display("[TB] FAIL reseed_to_ready got %0d want 25", n); end
        checks++;
        if (random_vect_o !== vec1_ref) begin errors++; $display("[TB] FAIL reseed_vect got %h want %h", random_vect_o, vec1_ref); end
    endtask

    task automatic test_reseed_take();
        logic [W*D-1:0] prev;
        logic [W*D-1:0] want;
        prev = m_front;
        want = scrub_on() ? '0 : prev;
        tick(1, $urandom, 1);
        checks++;
        if (underflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reseed_take_uf got %b want 0", underflow_o); end
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("[TB] FAIL reseed_take_rdy got %b want 0", rdy_o); end
        tick(0, 0, 0);
        checks++;
        if (random_vect_o !== want) begin errors++; $display("[TB] FAIL reseed_take_vect got %h want %h", random_vect_o, want); end
    endtask

    task automatic test_midfill_reset();
        int n;
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        tick(0, 0, 1);
        rst = 1'b0;
        tick(0, 0, 0);
        checks++;
        if (rdy_o !== 1'b0 || underflow_o !== 1'b0 || random_vect_o !== '0) begin
            errors++; $display("[TB] FAIL midfill_reset got rdy=%b uf=%b vect=%h want all 0", rdy_o, underflow_o, random_vect_o);
        end
        rst = 1'b1;
        n = 0;
        do begin
            tick(0, 0, 0);
            n++;
        end while (rdy_o !== 1'b1 && n < 60);
        checks++;
        if (n != 25) begin errors++; $display("[TB] FAIL post_reset_ready got %0d want 25", n); end
        checks++;
        if (random_vect_o !== vec1_ref) begin errors++; $display("[TB] FAIL post_reset_vect got %h want %h", random_vect_o, vec1_ref); end
    endtask

    task automatic test_random();
        bit          sl;
        bit          tk;
        logic [31:0] sd;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            sl  = ($urandom_range(0, 79) == 0);
            tk  = ($urandom_range(0, 5) == 0);
            sd  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            tick(sl, sd, tk);
            checks++;
            if (rdy_o !== m_rdy || underflow_o !== m_uf || random_vect_o !== m_front) begin
                errors++;
                $display("[TB] FAIL random_c%0d got rdy=%b uf=%b vect=%h want rdy=%b uf=%b vect=%h",
                         c, rdy_o, underflow_o, random_vect_o, m_rdy, m_uf, m_front);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        seed_i      = '0;
        seed_load_i = 1'b0;
        take_i      = 1'b0;
        m_lfsr      = SEED;
        m_full      = 0;
        m_front     = '0;
        m_rdy       = 0;
        m_uf        = 0;
        vec1_ref    = '0;
        test_reset();
        test_startup();
        test_take_full();
        test_underflow();
        test_reseed();
        test_reseed_take();
        test_midfill_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
